// File: rtl/shift_reg_pkg.sv
// Shared types for the universal shift register: mode/direction encodings and counter sizing.
// Types only; no latency or flow control here.
package shift_reg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

    typedef enum logic {
        DIR_SHR = 1'b0,
        DIR_SHL = 1'b1
    } dir_t;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/shift_frame_counter.sv
// Tracks the shift direction and counts same-direction shifts into WIDTH-bit frames.
// One-cycle latency to bit_cnt/dir/frame_done; no backpressure, accepts a shift every cycle.
module shift_frame_counter
    import shift_reg_pkg::*;
#(
    parameter int  WIDTH = 8,
    localparam int CW    = cnt_width(WIDTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          shift,
    input  dir_t          dir_in,
    input  logic          clear,
    output logic [CW-1:0] bit_cnt,
    output logic          frame_done,
    output dir_t          dir
);

    logic [CW:0] cnt_next;
    logic        wrap;

    // A reversing shift starts a new frame at 1, so a frame never mixes directions.
    always_comb begin
        cnt_next = (dir_in == dir) ? ({1'b0, bit_cnt} + (CW+1)'(1)) : (CW+1)'(1);
        wrap     = (cnt_next == (CW+1)'(WIDTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            frame_done <= 1'b0;
            dir        <= DIR_SHR;
        end else begin
            frame_done <= 1'b0;
            if (clear) begin
                bit_cnt <= '0;
            end else if (shift) begin
                dir <= dir_in;
                if (wrap) begin
                    bit_cnt    <= '0;
                    frame_done <= 1'b1;
                end else begin
                    bit_cnt <= cnt_next[CW-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/univ_shift_register.sv
// Universal shift register (hold / shift right / shift left / parallel load) with frame counter.
// One-cycle latency from clock edge to q; no backpressure, en=0 simply holds state.
module univ_shift_register
    import shift_reg_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int              CW      = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic [CW-1:0]    bit_cnt,
    output logic             frame_done
);

    mode_t            eff_mode;
    logic             shift;
    logic             clear;
    dir_t             dir_in;
    dir_t             dir;
    logic [WIDTH-1:0] shr_val;
    logic [WIDTH-1:0] shl_val;
    logic [WIDTH-1:0] q_next;

    always_comb begin
        eff_mode = en ? mode_t'(mode) : MODE_HOLD;
        shift    = (eff_mode == MODE_SHR) || (eff_mode == MODE_SHL);
        clear    = (eff_mode == MODE_LOAD);
        dir_in   = (eff_mode == MODE_SHL) ? DIR_SHL : DIR_SHR;
    end

    // A 1-bit register has nothing to keep, so both shift directions reduce to q <= sin.
    generate
        if (WIDTH == 1) begin : g_w1
            assign shr_val = sin;
            assign shl_val = sin;
        end else begin : g_wn
            assign shr_val = {sin, q[WIDTH-1:1]};
            assign shl_val = {q[WIDTH-2:0], sin};
        end
    endgenerate

    always_comb begin
        q_next = q;
        case (eff_mode)
            MODE_SHR:  q_next = shr_val;
            MODE_SHL:  q_next = shl_val;
            MODE_LOAD: q_next = pin;
            default:   q_next = q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else begin
            q <= q_next;
        end
    end

    assign sout = (dir == DIR_SHL) ? q[WIDTH-1] : q[0];

    shift_frame_counter #(
        .WIDTH (WIDTH)
    ) u_frame_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift      (shift),
        .dir_in     (dir_in),
        .clear      (clear),
        .bit_cnt    (bit_cnt),
        .frame_done (frame_done),
        .dir        (dir)
    );

endmodule
